// File: rtl/dmem_lat_ctrl.sv
// dmem_lat_ctrl: data memory with configurable read latency, valid/ready handshake, sub-word access and range checks.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors instead of masking the low address bits.
module dmem_lat_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LATENCY  = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [1:0]    size;
    logic          uns;
    logic          err;
  } ld_t;
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  ld_t         ld_q, ld_d, cur;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] offset, rd_word, ld_data, wdata_al;
  logic [3:0]  be;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [1:0]  off_lo;
  logic        is_word, is_half, oor, mis, req_err, accept, idle;
  always_comb begin
    offset  = req_addr - BASE_ADDR;
    oor     = offset >= 32'(DEPTH_WORDS * 4);
    is_word = req_size[1];
    is_half = req_size == 2'b01;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis     = (is_half & offset[0]) | (is_word & |offset[1:0]);
    off_lo  = offset[1:0];
`else
    mis     = 1'b0;
    off_lo  = is_word ? 2'b00 : is_half ? {offset[1], 1'b0} : offset[1:0];
`endif
    req_err = oor | mis;
  end
  assign idle      = state_q == IDLE;
  assign req_ready = idle;
  // the async reset also blocks accepts so nothing is written while it is held
  assign accept    = req_valid & idle & reset;
  assign cur       = '{idx: offset[AW+1:2], off: off_lo, size: req_size, uns: req_unsigned, err: req_err};
  assign ld_d      = accept ? cur : ld_q;
  always_comb begin
    be       = is_word ? 4'b1111 : is_half ? (off_lo[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off_lo;
    wdata_al = is_word ? req_wdata : is_half ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
  end
  always_ff @(posedge clk)
    if (accept & req_we & ~req_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[cur.idx][8*i +: 8] <= wdata_al[8*i +: 8];
  // a latency-1 load reads straight from the request; longer loads use the latched copy
  ld_t sel;
  assign sel = idle ? cur : ld_q;
  always_comb begin
    rd_word = mem[sel.idx];
    lane_b  = rd_word[{sel.off, 3'b000} +: 8];
    lane_h  = sel.off[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = sel.size[1] ? rd_word :
              sel.size[0] ? {{16{~sel.uns & lane_h[15]}}, lane_h} :
                            {{24{~sel.uns & lane_b[7]}}, lane_b};
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = (req_we || RD_LATENCY == 1) ? RESP : WAIT;
        cnt_d   = (req_we || RD_LATENCY == 1) ? 2'd0 : 2'(RD_LATENCY - 1);
      end
      WAIT: begin
        state_d = cnt_q == 2'd1 ? RESP : WAIT;
        cnt_d   = cnt_q - 2'd1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rsp_valid_d = state_d == RESP;
    rsp_err_d   = rsp_valid_d & sel.err;
    rsp_rdata_d = (rsp_valid_d & ~sel.err & ~(idle & req_we)) ? ld_data : 32'h0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      ld_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_lat_ctrl.sv
// tb_dmem_lat_ctrl: directed bench for dmem_lat_ctrl at RD_LATENCY = 3, DEPTH_WORDS = 1024.
module tb_dmem_lat_ctrl;
  localparam int LAT = 3;
  logic        clk = 0, reset = 0, req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int pass_cnt = 0, total_cnt = 0;
  always #5 clk = ~clk;
  dmem_lat_ctrl #(.DEPTH_WORDS(1024), .RD_LATENCY(LAT), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // call just after a negedge; returns at the negedge where rsp_valid was seen
  task automatic xfer(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err, output int lat);
    int n = 0;
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    lat = 0; rdata = 32'hx; err = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = 0;
      lat++;
      if (rsp_valid) begin rdata = rsp_rdata; err = rsp_err; break; end
    end
  endtask
  task automatic st(input string tag, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata, input logic exp_err);
    logic [31:0] d; logic e; int l;
    xfer(1'b1, size, 1'b0, addr, wdata, d, e, l);
    chk({tag, "_lat"}, l, 1);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    chk({tag, "_rdata"}, d, 32'h0);
  endtask
  task automatic ld(input string tag, input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_err);
    logic [31:0] d; logic e; int l;
    xfer(1'b0, size, uns, addr, 32'h0, d, e, l);
    chk({tag, "_lat"}, l, LAT);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    chk({tag, "_rdata"}, d, exp_d);
  endtask
  initial begin
    #100000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    reset = 1;
    @(negedge clk);
    chk("first_accept", {31'b0, rsp_valid}, 1);
    chk("first_err", {31'b0, rsp_err}, 0);
    req_valid = 0;
    @(negedge clk);
    chk("ready_after", {31'b0, req_ready}, 1);
    ld("ld30", 2'b10, 0, 32'h30, 32'h1234_5678, 0);
    st("sw10", 2'b10, 32'h10, 32'hDEAD_BEEF, 0);
    ld("lw10", 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0);
    st("sw10z", 2'b10, 32'h10, 32'h0, 0);
    st("sb13", 2'b00, 32'h13, 32'hAAAA_AA80, 0);
    ld("lb13", 2'b00, 0, 32'h13, 32'hFFFF_FF80, 0);
    ld("lbu13", 2'b00, 1, 32'h13, 32'h0000_0080, 0);
    ld("lw10b", 2'b10, 1, 32'h10, 32'h8000_0000, 0);
    st("sw20z", 2'b10, 32'h20, 32'h0, 0);
    st("sh22", 2'b01, 32'h22, 32'h1234_BEEF, 0);
    ld("lh22", 2'b01, 0, 32'h22, 32'hFFFF_BEEF, 0);
    ld("lhu22", 2'b01, 1, 32'h22, 32'h0000_BEEF, 0);
    ld("lh20", 2'b01, 0, 32'h20, 32'h0, 0);
    st("sw0", 2'b10, 32'h0, 32'hCAFE_F00D, 0);
    st("sw_oor", 2'b10, 32'h1000, 32'h1111_1111, 1);
    ld("lw0", 2'b10, 0, 32'h0, 32'hCAFE_F00D, 0);
    ld("lw_oor", 2'b10, 0, 32'hFFFF_FFFC, 32'h0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    ld("lw11", 2'b10, 0, 32'h11, 32'h0, 1);
`else
    ld("lw11", 2'b10, 0, 32'h11, 32'h8000_0000, 0);
`endif
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    reset = 0;
    @(negedge clk);
    chk("rst_wait_valid", {31'b0, rsp_valid}, 0);
    reset = 1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen = 1; end
    chk("no_rsp_after_rst", {31'b0, seen}, 0);
    chk("ready_after_rst", {31'b0, req_ready}, 1);
    ld("lw0_kept", 2'b10, 0, 32'h0, 32'hCAFE_F00D, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
